// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like port arbiter: requester IDs, command
// bundle width and the handshake lock states.
package sram_like_arbiter_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  // wr(1) + size(2) + wstrb(4) + addr(32) + wdata(32)
  localparam int SRAM_CMD_W = 71;

  typedef enum logic {
    LOCK_OFF = 1'b0,
    LOCK_ON  = 1'b1
  } lock_state_t;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for accepted-but-unanswered requests.
// Pops on an empty FIFO and pushes on a full FIFO are ignored.
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem_reg, mem_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             push_en, pop_en;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign mem_next[gi] = (push_en && (wr_ptr_reg == PW'(gi))) ? push_id : mem_reg[gi];
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_en) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      mem_reg    <= mem_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between the inst and data requesters, with
// handshake locking, starvation relief and in-order response routing.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int STARVE_LIM  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err_spurious
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  lock_state_t           lock_reg, lock_next;
  logic                  owner_reg, owner_next;
  logic [SW-1:0]         starve_reg, starve_next;
  logic                  err_reg, err_next;
  logic                  sel_id, sel_req, accept;
  logic                  fifo_full, fifo_empty, fifo_head, rsp_valid;
  logic [SRAM_CMD_W-1:0] i_cmd, d_cmd, sel_cmd;

  assign i_cmd = {i_wr, i_size, i_wstrb, i_addr, i_wdata};
  assign d_cmd = {d_wr, d_size, d_wstrb, d_addr, d_wdata};

  // A locked owner keeps the port until its command is accepted.
  always_comb begin
    sel_id = ARB_ID_INST;
    if (lock_reg == LOCK_ON) begin
      sel_id = owner_reg;
    end else if (i_req && d_req) begin
      sel_id = (starve_reg == STARVE_MAX) ? ARB_ID_INST : ARB_ID_DATA;
    end else if (d_req) begin
      sel_id = ARB_ID_DATA;
    end
  end

  assign sel_req   = (sel_id == ARB_ID_DATA) ? d_req : i_req;
  assign m_req     = sel_req & ~fifo_full;
  assign accept    = m_req & m_addr_ok;
  assign sel_cmd   = !sel_req ? '0 : ((sel_id == ARB_ID_DATA) ? d_cmd : i_cmd);
  assign {m_wr, m_size, m_wstrb, m_addr, m_wdata} = sel_cmd;
  assign i_addr_ok = accept & (sel_id == ARB_ID_INST);
  assign d_addr_ok = accept & (sel_id == ARB_ID_DATA);

  assign rsp_valid    = m_data_ok & ~fifo_empty;
  assign i_data_ok    = rsp_valid & (fifo_head == ARB_ID_INST);
  assign d_data_ok    = rsp_valid & (fifo_head == ARB_ID_DATA);
  assign i_rdata      = i_data_ok ? m_rdata : '0;
  assign d_rdata      = d_data_ok ? m_rdata : '0;
  assign err_spurious = err_reg;

  always_comb begin
    lock_next   = lock_reg;
    owner_next  = owner_reg;
    starve_next = starve_reg;
    err_next    = err_reg | (m_data_ok & fifo_empty);
    case (lock_reg)
      LOCK_OFF: begin
        if (m_req && !m_addr_ok) begin
          lock_next  = LOCK_ON;
          owner_next = sel_id;
        end
      end
      LOCK_ON: begin
        if (accept) lock_next = LOCK_OFF;
      end
      default: lock_next = LOCK_OFF;
    endcase
    // Count consecutive data grants that left inst waiting.
    if (!i_req) begin
      starve_next = '0;
    end else if (accept && sel_id == ARB_ID_INST) begin
      starve_next = '0;
    end else if (accept && starve_reg != STARVE_MAX) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_reg   <= LOCK_OFF;
      owner_reg  <= ARB_ID_INST;
      starve_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      lock_reg   <= lock_next;
      owner_reg  <= owner_next;
      starve_reg <= starve_next;
      err_reg    <= err_next;
    end
  end

  arb_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .push_id(sel_id),
    .pop    (m_data_ok),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// transaction-level model (queue of outstanding IDs, grant rules).
module tb_sram_like_arbiter;

  localparam int OUTSTANDING = 2;
  localparam int STARVE_LIM  = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [3:0]  i_wstrb, d_wstrb;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        err_spurious;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  bit mdl_q[$];
  bit mdl_lock;
  bit mdl_owner;
  int mdl_starve;
  bit mdl_err;
  // Model predictions for the current cycle
  bit        e_sel, e_mreq, e_iaok, e_daok, e_idok, e_ddok;
  logic [31:0] e_irdata, e_drdata;

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .OUTSTANDING(OUTSTANDING),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .err_spurious(err_spurious)
  );

  task automatic idle_inputs();
    i_req = 0; i_wr = 0; i_size = 0; i_wstrb = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    idle_inputs();
    mdl_q.delete();
    mdl_lock = 0; mdl_owner = 0; mdl_starve = 0; mdl_err = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  // Grant rules: locked owner first, lone requester next, data preferred
  // unless inst has waited through STARVE_LIM data grants.
  task automatic predict();
    bit has;
    if (mdl_lock)                e_sel = mdl_owner;
    else if (i_req && d_req)     e_sel = (mdl_starve == STARVE_LIM) ? 1'b0 : 1'b1;
    else                         e_sel = d_req;
    e_mreq   = (e_sel ? d_req : i_req) && (mdl_q.size() < OUTSTANDING);
    e_iaok   = e_mreq && m_addr_ok && !e_sel;
    e_daok   = e_mreq && m_addr_ok && e_sel;
    has      = mdl_q.size() > 0;
    e_idok   = m_data_ok && has && (mdl_q[0] == 1'b0);
    e_ddok   = m_data_ok && has && (mdl_q[0] == 1'b1);
    e_irdata = e_idok ? m_rdata : 32'h0;
    e_drdata = e_ddok ? m_rdata : 32'h0;
  endtask

  task automatic model_update();
    bit acc;
    acc = e_mreq && m_addr_ok;
    if (m_data_ok) begin
      if (mdl_q.size() > 0) void'(mdl_q.pop_front());
      else mdl_err = 1;
    end
    if (acc) mdl_q.push_back(e_sel);
    if (acc) mdl_lock = 0;
    else if (e_mreq) begin mdl_lock = 1; mdl_owner = e_sel; end
    if (!i_req) mdl_starve = 0;
    else if (acc && !e_sel) mdl_starve = 0;
    else if (acc && mdl_starve < STARVE_LIM) mdl_starve++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    tests_run++;
    if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, err_spurious} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000000",
               {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, err_spurious});
    end
    tests_run++;
    if ({m_wr, m_size, m_wstrb, m_addr, m_wdata, i_rdata, d_rdata} !== 135'h0) begin
      tests_failed++;
      $display("FAIL reset_buses: got addr=%h wdata=%h irdata=%h drdata=%h expected all 0",
               m_addr, m_wdata, i_rdata, d_rdata);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    i_req = 1; i_size = 2; i_addr = 32'h1c00_0000; m_addr_ok = 1; #1;
    tests_run++;
    if ({i_addr_ok, d_addr_ok, m_req, m_addr} !== {3'b101, 32'h1c00_0000}) begin
      tests_failed++;
      $display("FAIL single_accept: got iok=%b dok=%b req=%b addr=%h expected 1 0 1 1c000000",
               i_addr_ok, d_addr_ok, m_req, m_addr);
    end
    @(negedge clk);
    i_req = 0; m_addr_ok = 0; #1;
    tests_run++;
    if ({m_req, i_data_ok} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_gap: got req=%b idok=%b expected 0 0", m_req, i_data_ok);
    end
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'hA5A5_0001; #1;
    tests_run++;
    if ({i_data_ok, d_data_ok, i_rdata, d_rdata} !== {2'b10, 32'hA5A5_0001, 32'h0}) begin
      tests_failed++;
      $display("FAIL single_resp: got idok=%b ddok=%b irdata=%h drdata=%h expected 1 0 a5a50001 0",
               i_data_ok, d_data_ok, i_rdata, d_rdata);
    end
    @(negedge clk);
    m_data_ok = 0;
  endtask

  task automatic test_starvation();
    bit exp_d[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_req = 1; d_req = 1; i_addr = 32'h100 + k; d_addr = 32'h200 + k;
      m_addr_ok = 1; m_data_ok = (k > 0); m_rdata = k; #1;
      tests_run++;
      if ({i_addr_ok, d_addr_ok} !== {~exp_d[k], exp_d[k]}) begin
        tests_failed++;
        $display("FAIL starve_grant[%0d]: got iok=%b dok=%b expected %b %b",
                 k, i_addr_ok, d_addr_ok, ~exp_d[k], exp_d[k]);
      end
      if (k > 0) begin
        tests_run++;
        if ({i_data_ok, d_data_ok} !== {~exp_d[k-1], exp_d[k-1]}) begin
          tests_failed++;
          $display("FAIL starve_route[%0d]: got idok=%b ddok=%b expected %b %b",
                   k, i_data_ok, d_data_ok, ~exp_d[k-1], exp_d[k-1]);
        end
      end
    end
    @(negedge clk);
    i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 1; #1;
    tests_run++;
    if ({i_data_ok, d_data_ok} !== 2'b10) begin
      tests_failed++;
      $display("FAIL starve_last_route: got idok=%b ddok=%b expected 1 0", i_data_ok, d_data_ok);
    end
    @(negedge clk);
    m_data_ok = 0;
  endtask

  task automatic test_lock();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_req = 1; i_addr = 32'h1c00_0040; m_addr_ok = 0;
      if (c == 1) begin d_req = 1; d_addr = 32'h1c00_0080; end
      #1;
      tests_run++;
      if ({m_req, i_addr_ok, d_addr_ok, m_addr} !== {3'b100, 32'h1c00_0040}) begin
        tests_failed++;
        $display("FAIL lock_hold[%0d]: got req=%b iok=%b dok=%b addr=%h expected 1 0 0 1c000040",
                 c, m_req, i_addr_ok, d_addr_ok, m_addr);
      end
    end
    @(negedge clk);
    m_addr_ok = 1; #1;
    tests_run++;
    if ({i_addr_ok, d_addr_ok, m_addr} !== {2'b10, 32'h1c00_0040}) begin
      tests_failed++;
      $display("FAIL lock_accept: got iok=%b dok=%b addr=%h expected 1 0 1c000040",
               i_addr_ok, d_addr_ok, m_addr);
    end
    @(negedge clk);
    i_req = 0; #1;
    tests_run++;
    if ({d_addr_ok, m_addr} !== {1'b1, 32'h1c00_0080}) begin
      tests_failed++;
      $display("FAIL lock_next_data: got dok=%b addr=%h expected 1 1c000080", d_addr_ok, m_addr);
    end
    @(negedge clk);
    d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1; #1;
    tests_run++;
    if ({i_data_ok, d_data_ok, i_rdata} !== {2'b10, 32'h1}) begin
      tests_failed++;
      $display("FAIL lock_resp_i: got idok=%b ddok=%b irdata=%h expected 1 0 1", i_data_ok, d_data_ok, i_rdata);
    end
    @(negedge clk);
    m_rdata = 32'h2; #1;
    tests_run++;
    if ({i_data_ok, d_data_ok, d_rdata} !== {2'b01, 32'h2}) begin
      tests_failed++;
      $display("FAIL lock_resp_d: got idok=%b ddok=%b drdata=%h expected 0 1 2", i_data_ok, d_data_ok, d_rdata);
    end
    @(negedge clk);
    m_data_ok = 0;
  endtask

  task automatic test_full();
    do_reset();
    @(negedge clk);
    d_req = 1; d_addr = 32'h300; m_addr_ok = 1; #1;
    tests_run++;
    if (d_addr_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_acc0: got dok=%b expected 1", d_addr_ok);
    end
    @(negedge clk);
    d_addr = 32'h304; #1;
    tests_run++;
    if (d_addr_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_acc1: got dok=%b expected 1", d_addr_ok);
    end
    @(negedge clk);
    d_addr = 32'h308; i_req = 1; i_addr = 32'h400; #1;
    tests_run++;
    if ({m_req, i_addr_ok, d_addr_ok} !== 3'b000) begin
      tests_failed++;
      $display("FAIL full_block: got req=%b iok=%b dok=%b expected 0 0 0", m_req, i_addr_ok, d_addr_ok);
    end
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h11; #1;
    tests_run++;
    if ({m_req, d_data_ok} !== 2'b01) begin
      tests_failed++;
      $display("FAIL full_no_bypass: got req=%b ddok=%b expected 0 1", m_req, d_data_ok);
    end
    @(negedge clk);
    m_data_ok = 0; #1;
    tests_run++;
    if ({m_req, d_addr_ok} !== 2'b11) begin
      tests_failed++;
      $display("FAIL full_freed: got req=%b dok=%b expected 1 1", m_req, d_addr_ok);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_interleave();
    do_reset();
    @(negedge clk);
    i_req = 1; i_wr = 1; i_wstrb = 4'hF; i_addr = 32'h1c00_0100; i_wdata = 32'hCAFE_F00D; m_addr_ok = 1; #1;
    tests_run++;
    if ({i_addr_ok, m_wr, m_wstrb, m_wdata} !== {1'b1, 1'b1, 4'hF, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("FAIL ilv_write: got iok=%b wr=%b wstrb=%h wdata=%h expected 1 1 f cafef00d",
               i_addr_ok, m_wr, m_wstrb, m_wdata);
    end
    @(negedge clk);
    i_req = 0; i_wr = 0; i_wstrb = 0; d_req = 1; d_addr = 32'h1c00_0200; m_data_ok = 1; m_rdata = 0; #1;
    tests_run++;
    if ({d_addr_ok, i_data_ok, d_data_ok} !== 3'b110) begin
      tests_failed++;
      $display("FAIL ilv_c1: got dok=%b idok=%b ddok=%b expected 1 1 0", d_addr_ok, i_data_ok, d_data_ok);
    end
    @(negedge clk);
    d_req = 0; i_req = 1; i_addr = 32'h1c00_0104; m_rdata = 32'hDEAD_BEEF; #1;
    tests_run++;
    if ({i_addr_ok, i_data_ok, d_data_ok, d_rdata, i_rdata} !== {3'b101, 32'hDEAD_BEEF, 32'h0}) begin
      tests_failed++;
      $display("FAIL ilv_c2: got iok=%b idok=%b ddok=%b drdata=%h irdata=%h expected 1 0 1 deadbeef 0",
               i_addr_ok, i_data_ok, d_data_ok, d_rdata, i_rdata);
    end
    @(negedge clk);
    i_req = 0; m_addr_ok = 0; m_rdata = 32'h0BAD_F00D; #1;
    tests_run++;
    if ({i_data_ok, d_data_ok, i_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      tests_failed++;
      $display("FAIL ilv_c3: got idok=%b ddok=%b irdata=%h expected 1 0 0badf00d", i_data_ok, d_data_ok, i_rdata);
    end
    @(negedge clk);
    m_data_ok = 0;
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h55; #1;
    tests_run++;
    if ({i_data_ok, d_data_ok, i_rdata, d_rdata} !== 66'h0) begin
      tests_failed++;
      $display("FAIL spur_no_route: got idok=%b ddok=%b expected 0 0", i_data_ok, d_data_ok);
    end
    @(negedge clk);
    m_data_ok = 0; #1;
    tests_run++;
    if (err_spurious !== 1'b1) begin
      tests_failed++;
      $display("FAIL spur_flag: got %b expected 1", err_spurious);
    end
    @(negedge clk);
    i_req = 1; i_addr = 32'h1c00_0300; m_addr_ok = 1;
    @(negedge clk);
    i_req = 0; m_addr_ok = 0; #1;
    tests_run++;
    if (err_spurious !== 1'b1) begin
      tests_failed++;
      $display("FAIL spur_sticky: got %b expected 1", err_spurious);
    end
    #2 resetn = 0; #1;
    tests_run++;
    if (err_spurious !== 1'b0) begin
      tests_failed++;
      $display("FAIL spur_async_clear: got %b expected 0", err_spurious);
    end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h77; #1;
    tests_run++;
    if ({i_data_ok, d_data_ok} !== 2'b00) begin
      tests_failed++;
      $display("FAIL spur_fifo_cleared: got idok=%b ddok=%b expected 0 0", i_data_ok, d_data_ok);
    end
    @(negedge clk);
    m_data_ok = 0; #1;
    tests_run++;
    if (err_spurious !== 1'b1) begin
      tests_failed++;
      $display("FAIL spur_after_reset: got %b expected 1", err_spurious);
    end
  endtask

  task automatic test_random();
    bit i_done = 0, d_done = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (i_done) i_req = 0;
      if (d_done) d_req = 0;
      if (!i_req && ($urandom % 2 == 0)) begin
        i_req = 1; i_wr = 1'($urandom); i_size = 2'($urandom); i_wstrb = 4'($urandom);
        i_addr = $urandom; i_wdata = $urandom;
      end
      if (!d_req && ($urandom % 2 == 0)) begin
        d_req = 1; d_wr = 1'($urandom); d_size = 2'($urandom); d_wstrb = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      m_addr_ok = ($urandom % 4) != 0;
      m_data_ok = (mdl_q.size() > 0) && (($urandom % 3) != 0);
      m_rdata   = $urandom;
      #1;
      predict();
      tests_run++;
      if ({m_req, i_addr_ok, d_addr_ok} !== {e_mreq, e_iaok, e_daok}) begin
        tests_failed++;
        $display("FAIL rnd_grant[%0d]: got req=%b iok=%b dok=%b expected %b %b %b",
                 c, m_req, i_addr_ok, d_addr_ok, e_mreq, e_iaok, e_daok);
      end
      tests_run++;
      if ({i_data_ok, d_data_ok, i_rdata, d_rdata} !== {e_idok, e_ddok, e_irdata, e_drdata}) begin
        tests_failed++;
        $display("FAIL rnd_route[%0d]: got idok=%b ddok=%b irdata=%h drdata=%h expected %b %b %h %h",
                 c, i_data_ok, d_data_ok, i_rdata, d_rdata, e_idok, e_ddok, e_irdata, e_drdata);
      end
      if (e_mreq) begin
        tests_run++;
        if ({m_wr, m_addr, m_wdata} !== (e_sel ? {d_wr, d_addr, d_wdata} : {i_wr, i_addr, i_wdata})) begin
          tests_failed++;
          $display("FAIL rnd_cmd[%0d]: got wr=%b addr=%h wdata=%h for requester %0d",
                   c, m_wr, m_addr, m_wdata, e_sel);
        end
      end
      tests_run++;
      if (err_spurious !== mdl_err) begin
        tests_failed++;
        $display("FAIL rnd_err[%0d]: got %b expected %b", c, err_spurious, mdl_err);
      end
      @(posedge clk);
      i_done = e_iaok;
      d_done = e_daok;
      model_update();
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_starvation();
    test_lock();
    test_full();
    test_interleave();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
